// File: rtl/calib_sequencer.sv
// Two-axis sweep-and-return calibration controller for the light tracker servo/ADC pair.
// Optional watchdog on handshakes and sample waits is enabled by defining CAL_TIMEOUT_EN.
module calib_sequencer #(
  parameter int DATA_W      = 12,
  parameter int CNT_W       = 9,
  parameter int SWEEP_STEPS = 256,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  output logic              STEP_REQ,
  output logic              STEP_DIR,
  input  logic              STEP_ACK,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] SAMPLE,
  output logic              AXIS,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] MAX_VAL,
  output logic [CNT_W-1:0]  MAX_POS,
  output logic              ERR
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_STEP   = CNT_W'(SWEEP_STEPS);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_SETTLE, S_SAMPLE, S_RETURN, S_NEXT_AXIS, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]  since_max_q, since_max_d;
  logic              max_seen_q, max_seen_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [CNT_W-1:0]  max_pos_q, max_pos_d;
  logic              axis_q, axis_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              gap_q, gap_d;
  logic              ack;
  logic              abort_go;

  assign ack = STEP_ACK && STEP_REQ;
  // An outstanding request is never withdrawn: abort waits for the acknowledging edge.
  assign abort_go = ABORT && (state_q != S_IDLE) && (state_q != S_FINISH) &&
                    (!STEP_REQ || STEP_ACK);

`ifdef CAL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic             waiting, wait_clr, timeout;

  assign waiting  = STEP_REQ || (state_q == S_SAMPLE);
  assign wait_clr = ack || ((state_q == S_SAMPLE) && SAMPLE_VALID);
  assign timeout  = waiting && !wait_clr && (wait_q == TMO_LAST);
  assign wait_d   = (waiting && !wait_clr) ? wait_q + 1'b1 : '0;
  assign ERR      = err_q;
`else
  // Watchdog not built: ERR is a constant low.
  assign ERR = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      step_cnt_q  <= '0;
      since_max_q <= '0;
      max_seen_q  <= 1'b0;
      max_val_q   <= '0;
      max_pos_q   <= '0;
      axis_q      <= 1'b0;
      settle_q    <= '0;
      gap_q       <= 1'b0;
`ifdef CAL_TIMEOUT_EN
      wait_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      since_max_q <= since_max_d;
      max_seen_q  <= max_seen_d;
      max_val_q   <= max_val_d;
      max_pos_q   <= max_pos_d;
      axis_q      <= axis_d;
      settle_q    <= settle_d;
      gap_q       <= gap_d;
`ifdef CAL_TIMEOUT_EN
      wait_q      <= wait_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    since_max_d = since_max_q;
    max_seen_d  = max_seen_q;
    max_val_d   = max_val_q;
    max_pos_d   = max_pos_q;
    axis_d      = axis_q;
    settle_d    = settle_q;
    gap_d       = 1'b0;
`ifdef CAL_TIMEOUT_EN
    err_d       = err_q;
`endif
    if (abort_go) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d     = S_STEP;
            step_cnt_d  = '0;
            since_max_d = '0;
            max_seen_d  = 1'b0;
            max_val_d   = '0;
            max_pos_d   = '0;
            axis_d      = 1'b0;
`ifdef CAL_TIMEOUT_EN
            err_d       = 1'b0;
`endif
          end
        end
        S_STEP: begin
          if (ack) begin
            step_cnt_d = step_cnt_q + 1'b1;
            settle_d   = '0;
            state_d    = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
          else settle_d = settle_q + 1'b1;
        end
        S_SAMPLE: begin
          if (SAMPLE_VALID) begin
            // Strictly greater keeps the earliest position on ties.
            if (!max_seen_q || (SAMPLE > max_val_q)) begin
              max_val_d   = SAMPLE;
              max_pos_d   = step_cnt_q;
              since_max_d = '0;
              max_seen_d  = 1'b1;
            end else begin
              since_max_d = since_max_q + 1'b1;
            end
            state_d = (step_cnt_q == LAST_STEP) ? S_RETURN : S_STEP;
          end
        end
        S_RETURN: begin
          // gap_q forces one idle cycle on STEP_REQ between reverse steps.
          if (since_max_q == '0) begin
            state_d = S_NEXT_AXIS;
          end else if (ack) begin
            since_max_d = since_max_q - 1'b1;
            gap_d       = 1'b1;
          end
        end
        S_NEXT_AXIS: begin
          if (!axis_q) begin
            axis_d      = 1'b1;
            step_cnt_d  = '0;
            since_max_d = '0;
            max_seen_d  = 1'b0;
            max_val_d   = '0;
            max_pos_d   = '0;
            state_d     = S_STEP;
          end else begin
            state_d = S_FINISH;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
`ifdef CAL_TIMEOUT_EN
      if (timeout) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    STEP_REQ = (state_q == S_STEP) ||
               ((state_q == S_RETURN) && (since_max_q != '0) && !gap_q);
    STEP_DIR = (state_q == S_RETURN);
    BUSY     = (state_q != S_IDLE) && (state_q != S_FINISH);
    DONE     = (state_q == S_FINISH);
    AXIS     = axis_q;
    MAX_VAL  = max_val_q;
    MAX_POS  = max_pos_q;
  end

endmodule

// File: tb/tb_calib_sequencer.sv
// Directed bench for calib_sequencer: table of full two-axis runs plus abort/reset/timeout sequences.
// Servo model acknowledges three cycles after a request; the ADC strobes every cycle.
module tb_calib_sequencer;
  localparam int DW = 12;
  localparam int CW = 9;

  logic          CLK = 1'b0;
  logic          RESET, START, ABORT, STEP_ACK, SAMPLE_VALID;
  logic [DW-1:0] SAMPLE;
  logic          STEP_REQ, STEP_DIR, AXIS, BUSY, DONE, ERR;
  logic [DW-1:0] MAX_VAL;
  logic [CW-1:0] MAX_POS;

  calib_sequencer #(
    .DATA_W(DW), .CNT_W(CW), .SWEEP_STEPS(8), .SETTLE_CYC(2), .TIMEOUT_CYC(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .STEP_REQ(STEP_REQ), .STEP_DIR(STEP_DIR), .STEP_ACK(STEP_ACK),
    .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE(SAMPLE), .AXIS(AXIS), .BUSY(BUSY),
    .DONE(DONE), .MAX_VAL(MAX_VAL), .MAX_POS(MAX_POS), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0][DW-1:0] hs;
    logic [7:0][DW-1:0] vs;
    int hmax, hpos, hrev, vmax, vpos, vrev;
  } run_t;

  int checks = 0;
  int errors = 0;
  bit ack_en = 1'b1;
  int fwd[2];
  int rev[2];
  logic [7:0][DW-1:0] cur_s[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0][DW-1:0] mk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][DW-1:0] r;
    r[0] = DW'(a0); r[1] = DW'(a1); r[2] = DW'(a2); r[3] = DW'(a3);
    r[4] = DW'(a4); r[5] = DW'(a5); r[6] = DW'(a6); r[7] = DW'(a7);
    return r;
  endfunction

  task automatic start_pulse();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, STEP_REQ, 0);
    chk({tag, "_dir"}, STEP_DIR, 0);
    chk({tag, "_axis"}, AXIS, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_maxval"}, MAX_VAL, 0);
    chk({tag, "_maxpos"}, MAX_POS, 0);
  endtask

  // Servo driver and ADC: ack on the third request cycle, present the next sample after each forward ack.
  initial begin
    int wcnt;
    wcnt = 0;
    STEP_ACK = 1'b0;
    SAMPLE = '0;
    forever begin
      @(posedge CLK); #1;
      STEP_ACK = 1'b0;
      if (STEP_REQ === 1'b1 && ack_en) begin
        wcnt++;
        if (wcnt == 3) begin
          STEP_ACK = 1'b1;
          wcnt = 0;
          if (STEP_DIR) rev[AXIS]++;
          else begin
            if (fwd[AXIS] < 8) SAMPLE = cur_s[AXIS][fwd[AXIS]];
            fwd[AXIS]++;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    run_t runs[3];
    int hmax, hpos, done_cnt, reqc;
    bit seen_done, vclr, found, got_ack;

    runs[0].hs = mk8(10, 30, 20, 30, 5, 5, 5, 5);
    runs[0].vs = mk8(1, 2, 3, 4, 5, 6, 7, 8);
    runs[0].hmax = 30;   runs[0].hpos = 2; runs[0].hrev = 6;
    runs[0].vmax = 8;    runs[0].vpos = 8; runs[0].vrev = 0;
    runs[1].hs = mk8(50, 0, 0, 0, 0, 0, 0, 0);
    runs[1].vs = mk8(0, 0, 0, 0, 0, 0, 0, 0);
    runs[1].hmax = 50;   runs[1].hpos = 1; runs[1].hrev = 7;
    runs[1].vmax = 0;    runs[1].vpos = 1; runs[1].vrev = 7;
    runs[2].hs = mk8(5, 9, 4095, 4095, 3, 2, 1, 0);
    runs[2].vs = mk8(100, 200, 150, 250, 250, 10, 20, 30);
    runs[2].hmax = 4095; runs[2].hpos = 3; runs[2].hrev = 5;
    runs[2].vmax = 250;  runs[2].vpos = 4; runs[2].vrev = 4;

    fwd = '{0, 0}; rev = '{0, 0};
    cur_s[0] = runs[0].hs; cur_s[1] = runs[0].vs;
    RESET = 1'b0; START = 1'b0; ABORT = 1'b0; SAMPLE_VALID = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("rst");
    @(posedge CLK); #1 RESET = 1'b1;

    for (int r = 0; r < 3; r++) begin
      fwd = '{0, 0}; rev = '{0, 0};
      cur_s[0] = runs[r].hs; cur_s[1] = runs[r].vs;
      hmax = -1; hpos = -1;
      start_pulse();
      @(negedge CLK);
      chk("busy_after_start", BUSY, 1);
      chk("axis_start", AXIS, 0);
      seen_done = 0; vclr = 0; done_cnt = 0;
      for (int c = 0; c < 2000 && !seen_done; c++) begin
        @(negedge CLK);
        if (!AXIS && BUSY) begin hmax = MAX_VAL; hpos = MAX_POS; end
        if (AXIS && !vclr) begin
          vclr = 1;
          chk("vert_clear_val", MAX_VAL, 0);
          chk("vert_clear_pos", MAX_POS, 0);
        end
        if (DONE) begin
          seen_done = 1; done_cnt++;
          chk("busy_at_done", BUSY, 0);
        end
      end
      chk("done_seen", seen_done, 1);
      repeat (4) begin @(negedge CLK); if (DONE) done_cnt++; end
      chk("done_once", done_cnt, 1);
      chk("h_max_val", hmax, runs[r].hmax);
      chk("h_max_pos", hpos, runs[r].hpos);
      chk("h_fwd", fwd[0], 8);
      chk("h_rev", rev[0], runs[r].hrev);
      chk("h_acks_total", fwd[0] + rev[0], 8 + runs[r].hrev);
      chk("v_max_val", MAX_VAL, runs[r].vmax);
      chk("v_max_pos", MAX_POS, runs[r].vpos);
      chk("v_fwd", fwd[1], 8);
      chk("v_rev", rev[1], runs[r].vrev);
      chk("idle_busy", BUSY, 0);
      chk("idle_err", ERR, 0);
    end

    // Abort while the second forward request is outstanding; START during BUSY is ignored.
    fwd = '{0, 0}; rev = '{0, 0};
    cur_s[0] = runs[0].hs; cur_s[1] = runs[0].vs;
    done_cnt = 0;
    start_pulse();
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge CLK);
      if (STEP_REQ && !STEP_ACK && fwd[0] == 1) found = 1;
    end
    chk("abort_req_found", found, 1);
    @(posedge CLK); #1 ABORT = 1'b1; START = 1'b1;
    @(negedge CLK);
    chk("abort_hold_req", STEP_REQ, 1);
    chk("abort_hold_busy", BUSY, 1);
    @(posedge CLK); #1 START = 1'b0;
    got_ack = 0;
    for (int c = 0; c < 20 && !got_ack; c++) begin
      @(negedge CLK);
      if (STEP_ACK) got_ack = 1;
      else chk("abort_wait_req", STEP_REQ, 1);
      if (DONE) done_cnt++;
    end
    chk("abort_ack_seen", got_ack, 1);
    @(negedge CLK);
    chk("abort_busy", BUSY, 0);
    chk("abort_req", STEP_REQ, 0);
    chk("abort_hold_val", MAX_VAL, 10);
    chk("abort_hold_pos", MAX_POS, 1);
    repeat (3) begin @(negedge CLK); if (DONE || BUSY) done_cnt++; end
    chk("abort_quiet", done_cnt, 0);

    // START with ABORT held in IDLE: START wins, abort follows at the next ack.
    start_pulse();
    @(negedge CLK);
    chk("start_wins_busy", BUSY, 1);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge CLK);
      if (DONE) done_cnt++;
      if (!BUSY) found = 1;
    end
    chk("start_wins_abort", found, 1);
    chk("start_wins_nodone", done_cnt, 0);
    @(posedge CLK); #1 ABORT = 1'b0;

    // Reset during the first SETTLE cycle of the vertical axis.
    fwd = '{0, 0}; rev = '{0, 0};
    start_pulse();
    found = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge CLK);
      if (AXIS && STEP_ACK && !STEP_DIR) found = 1;
    end
    chk("rst_mid_found", found, 1);
    @(posedge CLK); #1 RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("rst_mid");
    @(posedge CLK); #1 RESET = 1'b1;

`ifdef CAL_TIMEOUT_EN
    ack_en = 1'b0;
    start_pulse();
    reqc = 0; found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge CLK);
      if (STEP_REQ) reqc++;
      else if (reqc > 0) found = 1;
    end
    chk("tmo_req_cycles", reqc, 16);
    chk("tmo_err", ERR, 1);
    chk("tmo_busy", BUSY, 0);
    chk("tmo_req", STEP_REQ, 0);
    ack_en = 1'b1;
    start_pulse();
    @(negedge CLK);
    chk("tmo_err_clear", ERR, 0);
    @(posedge CLK); #1 RESET = 1'b0;
    @(posedge CLK); #1 RESET = 1'b1;
`else
    reqc = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
